// File: rtl/pitch_meter.sv
// pitch_meter: measures the period of a square-wave audio comparator output.
// Mic is synchronised and edge-detected. The first rising edge arms the
// meter. Each later edge spaced at least MIN_PERIOD cycles from the last
// accepted edge contributes one period sample. Every 2^AVG_LOG2 samples the
// truncated average is published on Period, together with a one-cycle
// Period_Valid pulse. If no edge is accepted for TIMEOUT cycles, No_Signal
// is raised and the meter re-arms.
//
// Ports:
//   board_clk     in   system clock, rising edge
//   Reset         in   asynchronous, active-high reset
//   Enable        in   measurement enable; low forces IDLE
//   Mic           in   asynchronous square-wave input
//   Period        out  20-bit averaged period in board_clk cycles (held)
//   Period_Valid  out  one-cycle pulse when Period is updated
//   No_Signal     out  high while no valid tone is being tracked
module pitch_meter #(
   parameter int unsigned MIN_PERIOD = 25000,
   parameter int unsigned TIMEOUT    = 1000000,
   parameter int unsigned AVG_LOG2   = 2
) (
   input  logic        board_clk,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        Mic,
   output logic [19:0] Period,
   output logic        Period_Valid,
   output logic        No_Signal
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE
   } state_t;

   localparam int unsigned ACC_W = 20 + AVG_LOG2;
   localparam int unsigned NUM_W = AVG_LOG2 + 1;
   localparam logic [NUM_W-1:0] LAST_SAMPLE = NUM_W'((1 << AVG_LOG2) - 1);
   localparam logic [19:0] MIN_CNT     = 20'(MIN_PERIOD);
   localparam logic [19:0] TIMEOUT_CNT = 20'(TIMEOUT);

   // synchroniser and edge detector
   logic mic_meta_q, mic_sync_q, mic_prev_q;
   logic mic_rise;

   state_t           state_q,  state_d;
   logic [19:0]      cnt_q,    cnt_d;
   logic [ACC_W-1:0] acc_q,    acc_d;
   logic [NUM_W-1:0] num_q,    num_d;
   logic [19:0]      period_q, period_d;
   logic             valid_q,  valid_d;
   logic             nosig_q,  nosig_d;
   logic [ACC_W-1:0] sum;

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         mic_meta_q <= 1'b0;
         mic_sync_q <= 1'b0;
         mic_prev_q <= 1'b0;
      end else begin
         mic_meta_q <= Mic;
         mic_sync_q <= mic_meta_q;
         mic_prev_q <= mic_sync_q;
      end
   end

   assign mic_rise = mic_sync_q & ~mic_prev_q;

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         num_q    <= '0;
         period_q <= '0;
         valid_q  <= 1'b0;
         nosig_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         num_q    <= num_d;
         period_q <= period_d;
         valid_q  <= valid_d;
         nosig_q  <= nosig_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      num_d    = num_q;
      period_d = period_q;
      valid_d  = 1'b0;
      nosig_d  = nosig_q;
      // cnt_q is the current sample: cycles since the last accepted edge
      sum      = acc_q + ACC_W'(cnt_q);

      // Enable low wins over everything, including a completing edge
      if (!Enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         acc_d   = '0;
         num_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d   = '0;
               acc_d   = '0;
               num_d   = '0;
               state_d = ARM;
            end

            ARM: begin
               cnt_d = cnt_q + 20'd1;
               if (mic_rise) begin
                  // arming edge: no spacing check, starts the first sample
                  cnt_d   = 20'd1;
                  acc_d   = '0;
                  num_d   = '0;
                  state_d = MEASURE;
               end else if (cnt_q >= TIMEOUT_CNT) begin
                  nosig_d = 1'b1;
                  cnt_d   = '0;
                  acc_d   = '0;
                  num_d   = '0;
               end
            end

            MEASURE: begin
               cnt_d = cnt_q + 20'd1;
               // an accepted edge takes priority over a coincident timeout
               if (mic_rise && (cnt_q >= MIN_CNT)) begin
                  cnt_d = 20'd1;
                  if (num_q == LAST_SAMPLE) begin
                     period_d = 20'(sum >> AVG_LOG2);
                     valid_d  = 1'b1;
                     nosig_d  = 1'b0;
                     acc_d    = '0;
                     num_d    = '0;
                  end else begin
                     acc_d = sum;
                     num_d = num_q + NUM_W'(1);
                  end
               end else if (cnt_q >= TIMEOUT_CNT) begin
                  nosig_d = 1'b1;
                  cnt_d   = '0;
                  acc_d   = '0;
                  num_d   = '0;
                  state_d = ARM;
               end
            end

            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               acc_d   = '0;
               num_d   = '0;
            end
         endcase
      end
   end

   assign Period       = period_q;
   assign Period_Valid = valid_q;
   assign No_Signal    = nosig_q;

endmodule
